// File: rtl/approx_adder_error_sweeper_if.sv
// Host/adder-side bundle of the approximate-adder error sweeper.
// master: the sweeper; slave: the harness that owns the adder and host handshake.
interface approx_adder_error_sweeper_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH:0]     approx_sum;
  logic               busy;
  logic               done;
  logic [2*WIDTH:0]   err_count;
  logic [3*WIDTH:0]   sad;
  logic [WIDTH:0]     max_err;
  logic [WIDTH:0]     mae;

  modport master (
    input  start, abort, approx_sum,
    output op_a, op_b, busy, done, err_count, sad, max_err, mae
  );

  modport slave (
    output start, abort, approx_sum,
    input  op_a, op_b, busy, done, err_count, sad, max_err, mae
  );
endinterface

// File: rtl/approx_adder_error_sweeper.sv
// Exhaustive sweeper for a WIDTH-bit approximate adder: walks every operand pair,
// aligns the exact sum with the adder's latency and accumulates error metrics.
module approx_adder_error_sweeper #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  approx_adder_error_sweeper_if.master  bus
);

  localparam int unsigned CNT_W = 2 * WIDTH;
  localparam int unsigned ERR_W = 2 * WIDTH + 1;
  localparam int unsigned SAD_W = 3 * WIDTH + 1;
  localparam logic [1:0]  DRAIN_LAST = (DUT_LAT > 0) ? 2'(DUT_LAT - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         drain_q, drain_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [SAD_W-1:0]   sad_q, sad_d;
  logic [WIDTH:0]     max_q, max_d;

  logic               busy;
  logic               abort_take;
  logic               sweeping;
  logic [WIDTH:0]     exact_now;
  logic               cmp_vld;
  logic [WIDTH:0]     cmp_exact;
  logic [WIDTH:0]     err_abs;
  logic               acc_en;

  assign busy       = (state_q == SWEEP) || (state_q == DRAIN);
  assign abort_take = busy && bus.abort;
  assign sweeping   = (state_q == SWEEP);
  assign exact_now  = {1'b0, cnt_q[CNT_W-1:WIDTH]} + {1'b0, cnt_q[WIDTH-1:0]};

  // Delay line carrying each exact sum beside its valid bit until the adder catches up
  if (DUT_LAT == 0) begin : g_comb
    assign cmp_vld   = sweeping;
    assign cmp_exact = exact_now;
  end else begin : g_pipe
    logic [DUT_LAT-1:0]          vld_q;
    logic [DUT_LAT-1:0][WIDTH:0] ex_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        ex_q  <= '0;
      end else begin
        ex_q[0] <= exact_now;
        for (int unsigned i = 1; i < DUT_LAT; i++) begin
          ex_q[i] <= ex_q[i-1];
        end
        if (abort_take) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= sweeping;
          for (int unsigned i = 1; i < DUT_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
    end

    assign cmp_vld   = vld_q[DUT_LAT-1];
    assign cmp_exact = ex_q[DUT_LAT-1];
  end

  assign err_abs = (bus.approx_sum >= cmp_exact) ? (bus.approx_sum - cmp_exact)
                                                 : (cmp_exact - bus.approx_sum);
  // The comparison in flight on the abort edge is dropped so partial results stay put
  assign acc_en  = cmp_vld && !abort_take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    err_d   = err_q;
    sad_d   = sad_q;
    max_d   = max_q;

    if (acc_en) begin
      err_d = err_q + ERR_W'(err_abs != '0);
      sad_d = sad_q + SAD_W'(err_abs);
      if (err_abs > max_q) begin
        max_d = err_abs;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          err_d   = '0;
          sad_d   = '0;
          max_d   = '0;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (&cnt_q) begin
          state_d = (DUT_LAT == 0) ? DONE : DRAIN;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      sad_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      sad_q   <= sad_d;
      max_q   <= max_d;
    end
  end

  assign bus.op_a      = cnt_q[CNT_W-1:WIDTH];
  assign bus.op_b      = cnt_q[WIDTH-1:0];
  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE);
  assign bus.err_count = err_q;
  assign bus.sad       = sad_q;
  assign bus.max_err   = max_q;
  assign bus.mae       = sad_q[3*WIDTH:2*WIDTH];

endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Directed bench: three sweepers (exact comb adder, exact+1 with two-cycle latency,
// 2-bit adder stuck at zero) driven through a linear sequence of steps.
module tb_approx_adder_error_sweeper;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cnt;
  int   d0;
  int   d1;
  int   overlap;

  approx_adder_error_sweeper_if #(.WIDTH(8)) if0 ();
  approx_adder_error_sweeper_if #(.WIDTH(8)) if1 ();
  approx_adder_error_sweeper_if #(.WIDTH(2)) if2 ();

  approx_adder_error_sweeper #(.WIDTH(8), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master));
  approx_adder_error_sweeper #(.WIDTH(8), .DUT_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));
  approx_adder_error_sweeper #(.WIDTH(2), .DUT_LAT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master));

  // Adders under test
  logic [8:0] r1;
  logic [8:0] r2;
  assign if0.approx_sum = {1'b0, if0.op_a} + {1'b0, if0.op_b};
  always_ff @(posedge clk) begin
    r1 <= {1'b0, if1.op_a} + {1'b0, if1.op_b} + 9'd1;
    r2 <= r1;
  end
  assign if1.approx_sum = r2;
  assign if2.approx_sum = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0;
    if1.start = 1'b0; if1.abort = 1'b0;
    if2.start = 1'b0; if2.abort = 1'b0;
    #2;
    check("rst_busy0", 64'(if0.busy), 64'd0);
    check("rst_done1", 64'(if1.done), 64'd0);
    check("rst_err1", 64'(if1.err_count), 64'd0);
    check("rst_sad2", 64'(if2.sad), 64'd0);
    check("rst_ops2", 64'({if2.op_a, if2.op_b}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // W=2 stuck-at-zero adder: full sweep
    if2.start = 1'b1; tick(); if2.start = 1'b0;
    check("w2_busy_after_start", 64'(if2.busy), 64'd1);
    cnt = 0;
    do begin tick(); cnt++; end while (!if2.done && cnt < 100);
    check("w2_done_latency", 64'(cnt), 64'd16);
    check("w2_err_count", 64'(if2.err_count), 64'd15);
    check("w2_sad", 64'(if2.sad), 64'd48);
    check("w2_max_err", 64'(if2.max_err), 64'd6);
    check("w2_mae", 64'(if2.mae), 64'd3);
    check("w2_busy_at_done", 64'(if2.busy), 64'd0);

    // Relaunch from DONE, then a start pulse mid-sweep that must be ignored
    if2.start = 1'b1; tick(); if2.start = 1'b0;
    check("w2_relaunch_done", 64'(if2.done), 64'd0);
    check("w2_relaunch_busy", 64'(if2.busy), 64'd1);
    check("w2_relaunch_err", 64'(if2.err_count), 64'd0);
    check("w2_relaunch_sad", 64'(if2.sad), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    if2.start = 1'b1; tick(); if2.start = 1'b0;
    cnt = 5;
    do begin tick(); cnt++; end while (!if2.done && cnt < 100);
    check("w2_midstart_latency", 64'(cnt), 64'd16);
    check("w2_midstart_err", 64'(if2.err_count), 64'd15);

    // start+abort together while busy: abort wins, partial totals held
    if2.start = 1'b1; tick(); if2.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    if2.start = 1'b1; if2.abort = 1'b1; tick();
    if2.start = 1'b0; if2.abort = 1'b0;
    check("w2_sa_busy", 64'(if2.busy), 64'd0);
    check("w2_sa_done", 64'(if2.done), 64'd0);
    check("w2_sa_err", 64'(if2.err_count), 64'd2);
    check("w2_sa_sad", 64'(if2.sad), 64'd3);
    tick(); tick();
    check("w2_sa_idle", 64'(if2.busy), 64'd0);

    // W=8 abort at cycle 100
    if0.start = 1'b1; if1.start = 1'b1; tick();
    if0.start = 1'b0; if1.start = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    if0.abort = 1'b1; if1.abort = 1'b1; tick();
    if0.abort = 1'b0; if1.abort = 1'b0;
    check("ab_busy0", 64'(if0.busy), 64'd0);
    check("ab_busy1", 64'(if1.busy), 64'd0);
    check("ab_done1", 64'(if1.done), 64'd0);
    check("ab_err1", 64'(if1.err_count), 64'd97);
    check("ab_sad1", 64'(if1.sad), 64'd97);
    for (int i = 0; i < 5; i++) tick();
    check("ab_err1_held", 64'(if1.err_count), 64'd97);
    check("ab_busy1_held", 64'(if1.busy), 64'd0);

    // Asynchronous reset between edges mid-sweep
    if2.start = 1'b1; tick(); if2.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ar_err2_before", 64'(if2.err_count), 64'd4);
    check("ar_sad2_before", 64'(if2.sad), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy2", 64'(if2.busy), 64'd0);
    check("ar_err2", 64'(if2.err_count), 64'd0);
    check("ar_ops2", 64'({if2.op_a, if2.op_b}), 64'd0);
    check("ar_err1", 64'(if1.err_count), 64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("ar_idle_busy", 64'(if2.busy), 64'd0);
    check("ar_idle_done", 64'(if2.done), 64'd0);
    check("ar_idle_ops", 64'({if2.op_a, if2.op_b}), 64'd0);

    // Full W=8 sweeps: exact (latency 0) and exact+1 (latency 2) side by side
    if0.start = 1'b1; if1.start = 1'b1; tick();
    if0.start = 1'b0; if1.start = 1'b0;
    cnt = 0; d0 = 0; d1 = 0; overlap = 0;
    while ((d0 == 0 || d1 == 0) && cnt < 70000) begin
      tick(); cnt++;
      if (if0.done && d0 == 0) d0 = cnt;
      if (if1.done && d1 == 0) d1 = cnt;
      if ((if0.busy && if0.done) || (if1.busy && if1.done)) overlap++;
    end
    check("full0_latency", 64'(d0), 64'd65536);
    check("full1_latency", 64'(d1), 64'd65538);
    check("full_busy_done_overlap", 64'(overlap), 64'd0);
    check("full0_err", 64'(if0.err_count), 64'd0);
    check("full0_sad", 64'(if0.sad), 64'd0);
    check("full0_max", 64'(if0.max_err), 64'd0);
    check("full0_mae", 64'(if0.mae), 64'd0);
    check("full1_err", 64'(if1.err_count), 64'd65536);
    check("full1_sad", 64'(if1.sad), 64'd65536);
    check("full1_max", 64'(if1.max_err), 64'd1);
    check("full1_mae", 64'(if1.mae), 64'd1);
    tick(); tick();
    check("full1_done_held", 64'(if1.done), 64'd1);
    check("full1_ops_held", 64'({if1.op_a, if1.op_b}), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_adder_error_sweeper.md
Name: approx_adder_error_sweeper

Overview:
- Sequencer that exhaustively characterises one external WIDTH-bit approximate ripple-carry adder (IN1, IN2 -> WIDTH+1-bit Out).
- Drives every operand pair, computes the exact sum internally and accumulates error metrics: error count, sum of absolute error, maximum error and mean absolute error.
- Sits beside the approximate adder in the characterisation harness.
- Start/busy/done handshake toward a host; results are held until the next run.

Parameters:
- WIDTH, 8, operand width of the adder under test; legal range 2..12.
- DUT_LAT, 0, cycles from operands to adder result; legal range 0..3; 0 means a combinational adder.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle pulse; begins a sweep when the block is in IDLE or DONE.
- abort  input  1  stops a running sweep.
- op_a  output  WIDTH  operand to adder IN1.
- op_b  output  WIDTH  operand to adder IN2.
- approx_sum  input  WIDTH+1  adder Out.
- busy  output  1  high in SWEEP and DRAIN.
- done  output  1  high in DONE.
- err_count  output  2*WIDTH+1  number of pairs with a nonzero error.
- sad  output  3*WIDTH+1  sum of absolute errors.
- max_err  output  WIDTH+1  largest absolute error.
- mae  output  WIDTH+1  sad >> (2*WIDTH), truncated.

Behaviour:
- Reset: all outputs and counters are 0; the FSM is in IDLE.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start:
  - Clear err_count, sad and max_err.
  - Set op_a = op_b = 0.
  - Enter SWEEP.
- SWEEP:
  - Each cycle advances {op_a, op_b} as one 2*WIDTH-bit counter, with op_b as the low half.
  - After presenting the pair (2^WIDTH-1, 2^WIDTH-1), go to DRAIN.
  - If DUT_LAT = 0, go directly to DONE instead.
  - op_a and op_b are held at their final value until the next start.
- Exact-sum alignment:
  - exact = op_a + op_b, WIDTH+1 bits.
  - A DUT_LAT-deep delay line of exact sums and valid bits aligns each exact sum with approx_sum.
  - The pair presented in cycle t is compared in cycle t+DUT_LAT and accumulated at the following edge.
- Per valid comparison:
  - e = |approx_sum - exact|, WIDTH+1 bits.
  - sad += e.
  - err_count += (e != 0).
  - max_err = max(max_err, e).
  - No saturation is needed: the widths cover the worst case of 2^(2W) pairs each with error 2^(W+1)-1.
- DRAIN: lasts DUT_LAT cycles to flush the delay line, then enters DONE.
- Timing: done rises exactly N + DUT_LAT edges after the start edge, where N = 2^(2*WIDTH).
- busy is high from the edge after start until the edge on which done rises. busy and done are never high together.
- mae is combinational from sad. It is valid while done is high and reads the partial value otherwise.
- DONE: done and the results hold until start or reset.
- start while busy: ignored.
- start and abort in the same cycle: abort wins if busy; otherwise start wins.
- abort in SWEEP/DRAIN:
  - Go to IDLE at the next edge and flush the delay-line valid bits.
  - Accumulators hold their partial values; done stays 0.
- abort in IDLE/DONE: no effect.
- rst_n low at any time, including mid-sweep: immediate return to the reset values.
- Pairs presented before an abort or reset are never accumulated afterwards.

Test Plan:
- WIDTH=8, DUT_LAT=0, exact adder as DUT, one start pulse:
  - done rises 65536 cycles after the start edge.
  - err_count=0, sad=0, max_err=0, mae=0.
- WIDTH=8, DUT_LAT=2, DUT = exact+1 registered twice:
  - done rises at 65538 cycles.
  - err_count=65536, sad=65536, max_err=1, mae=1.
- WIDTH=2, DUT_LAT=0, DUT forces Out=0:
  - err_count=15, sad=48, max_err=6, mae=3, done after 16 cycles.
- WIDTH=8, start, abort at cycle 100:
  - busy drops at the next edge; done=0; FSM in IDLE.
  - A new start clears the accumulators and a full sweep gives the correct totals.
- Start pulse mid-sweep and start+abort in the same busy cycle:
  - The start is ignored in both cases; abort takes effect.
  - Start in DONE relaunches: done falls at the next edge and the counters clear.
- rst_n asserted asynchronously mid-sweep (between edges):
  - All outputs go to 0 immediately.
  - After release, the block idles until start.
